branch_resolve_ctrl: RTL

Sequencing controller for the EX-stage branch comparator. It accepts one conditional branch at a time from decode and drives the comparator's unsigned-select from funct3. It waits for forwarded operands, then samples the equal/less-than flags to resolve the branch and checks the result against the fetch-stage prediction. On a mispredict it issues a PC redirect and holds a pipeline flush for a fixed number of cycles.

---
 rtl/branch_resolve_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution sequencer: accepts one branch, waits for operands,
// resolves direction, checks prediction and drives redirect/flush.
// Optional BRANCH_STATS_EN macro adds branch and mispredict counters.
module branch_resolve_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_imm,
    input  logic        in_pred_taken,
    input  logic        op_ready,
    output logic        sign_select,
    input  logic        cmp_equal,
    input  logic        cmp_less_than,
    output logic        resolved_valid,
    output logic        resolved_taken,
    output logic        illegal_br,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        busy
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts,
    input  logic        stat_clear
`endif
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned XLEN  = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EVAL   = 2'd1,
        S_REPORT = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    state_t             r_state;
    logic [2:0]         r_funct3;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_imm;
    logic               r_pred;
    logic [CNT_W-1:0]   r_cnt;

    logic               r_in_ready;
    logic               r_sign_select;
    logic               r_resolved_valid;
    logic               r_resolved_taken;
    logic               r_illegal_br;
    logic               r_redirect_valid;
    logic [XLEN-1:0]    r_redirect_pc;
    logic               r_flush;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [2:0]         w_funct3_nxt;
    logic [XLEN-1:0]    w_pc_nxt;
    logic [XLEN-1:0]    w_imm_nxt;
    logic               w_pred_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_dec;
    logic               w_cmp_taken;
    logic               w_cmp_illegal;
    logic               w_mispred;
    logic               w_report;
    logic [XLEN-1:0]    w_target;

    // Branch direction from captured funct3 and live comparator flags
    always_comb begin
        w_cmp_taken   = 1'b0;
        w_cmp_illegal = 1'b0;
        case (r_funct3)
            3'b000:          w_cmp_taken = cmp_equal;
            3'b001:          w_cmp_taken = !cmp_equal;
            3'b100, 3'b110:  w_cmp_taken = cmp_less_than;
            3'b101, 3'b111:  w_cmp_taken = !cmp_less_than;
            default:         w_cmp_illegal = 1'b1;
        endcase
    end

    assign w_target  = w_cmp_taken ? (r_pc + r_imm) : (r_pc + XLEN'(4));
    assign w_cnt_dec = r_cnt - CNT_W'(1);

    // Next state, capture and next registered outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_funct3_nxt = r_funct3;
        w_pc_nxt     = r_pc;
        w_imm_nxt    = r_imm;
        w_pred_nxt   = r_pred;
        w_cnt_nxt    = r_cnt;
        w_mispred    = 1'b0;
        w_report     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_funct3_nxt = in_funct3;
                    w_pc_nxt     = in_pc;
                    w_imm_nxt    = in_imm;
                    w_pred_nxt   = in_pred_taken;
                    w_state_nxt  = S_EVAL;
                end
            end
            S_EVAL: begin
                if (op_ready) begin
                    w_report    = 1'b1;
                    w_mispred   = (w_cmp_taken != r_pred);
                    w_state_nxt = S_REPORT;
                end
            end
            S_REPORT: begin
                if (r_redirect_valid && (FLUSH_CYCLES > 32'd1)) begin
                    w_cnt_nxt   = CNT_W'(FLUSH_CYCLES - 32'd1);
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FLUSH: begin
                w_cnt_nxt = w_cnt_dec;
                if (w_cnt_dec == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_funct3         <= '0;
            r_pc             <= '0;
            r_imm            <= '0;
            r_pred           <= 1'b0;
            r_cnt            <= '0;
            r_in_ready       <= 1'b1;
            r_sign_select    <= 1'b0;
            r_resolved_valid <= 1'b0;
            r_resolved_taken <= 1'b0;
            r_illegal_br     <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_flush          <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_funct3         <= w_funct3_nxt;
            r_pc             <= w_pc_nxt;
            r_imm            <= w_imm_nxt;
            r_pred           <= w_pred_nxt;
            r_cnt            <= w_cnt_nxt;
            r_in_ready       <= (w_state_nxt == S_IDLE);
            r_busy           <= (w_state_nxt != S_IDLE);
            r_sign_select    <= (w_state_nxt == S_EVAL) && w_funct3_nxt[1];
            r_resolved_valid <= w_report;
            r_resolved_taken <= w_report && w_cmp_taken;
            r_illegal_br     <= w_report && w_cmp_illegal;
            r_redirect_valid <= w_mispred;
            r_redirect_pc    <= w_mispred ? w_target : '0;
            // First flush cycle coincides with REPORT
            r_flush          <= w_mispred || (w_state_nxt == S_FLUSH);
        end
    end

    assign in_ready       = r_in_ready;
    assign sign_select    = r_sign_select;
    assign resolved_valid = r_resolved_valid;
    assign resolved_taken = r_resolved_taken;
    assign illegal_br     = r_illegal_br;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush          = r_flush;
    assign busy           = r_busy;

`ifdef BRANCH_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    // Clear takes priority over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || stat_clear) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (r_resolved_valid) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (r_redirect_valid) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule
